// File: rtl/llc_set_buf_ctrl.sv
// LLC per-set buffer sequencer: fetches one set into the buffers, holds ownership
// for the pipeline, then walks every way and writes back the dirty ones.
module llc_set_buf_ctrl #(
  parameter int unsigned WAYS     = 16,
  parameter int unsigned WAY_BITS = 4,
  parameter int unsigned SET_BITS = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rst_state,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SET_BITS-1:0] req_set,
  input  logic                mem_gnt,
  output logic                mem_rd_en,
  output logic                mem_wr_en,
  output logic [SET_BITS-1:0] mem_set,
  output logic [WAY_BITS-1:0] mem_way,
  output logic                buf_load,
  output logic                busy,
  input  logic                release_vld,
  input  logic                release_wb,
  input  logic [WAYS-1:0]     dirty_bits,
  output logic                done
);

  typedef enum logic [2:0] {IDLE, RD, LATCH, OWN, WB} state_t;

  state_t              state;
  logic [SET_BITS-1:0] set_q;
  logic [WAY_BITS-1:0] way_q;
  logic [WAYS-1:0]     dirty_q;

  logic wb_advance;
  logic wb_last;

  // A clean way never waits for the arbiter; a dirty way waits for its grant.
  assign wb_advance = !dirty_q[way_q] || mem_gnt;
  assign wb_last    = (way_q == WAY_BITS'(WAYS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      set_q   <= '0;
      way_q   <= '0;
      dirty_q <= '0;
    end else if (rst_state) begin
      state   <= IDLE;
      way_q   <= '0;
      dirty_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            set_q <= req_set;
            state <= RD;
          end
        end
        RD: begin
          if (mem_gnt) state <= LATCH;
        end
        LATCH: state <= OWN;
        OWN: begin
          if (release_vld) begin
            if (release_wb) begin
              dirty_q <= dirty_bits;
              way_q   <= '0;
              state   <= WB;
            end else begin
              state <= IDLE;
            end
          end
        end
        WB: begin
          if (wb_advance) begin
            if (wb_last) begin
              way_q <= '0;
              state <= IDLE;
            end else begin
              way_q <= way_q + WAY_BITS'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; done is suppressed by an abort in the same cycle.
  always_comb begin
    req_ready = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_set   = '0;
    mem_way   = '0;
    buf_load  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  req_ready = 1'b1;
      RD: begin
        mem_rd_en = 1'b1;
        mem_set   = set_q;
      end
      LATCH: buf_load = 1'b1;
      OWN: begin
        busy = 1'b1;
        done = release_vld && !release_wb && !rst_state;
      end
      WB: begin
        mem_set   = set_q;
        mem_way   = way_q;
        mem_wr_en = dirty_q[way_q];
        done      = wb_advance && wb_last && !rst_state;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_llc_set_buf_ctrl.sv
// Self-checking bench for llc_set_buf_ctrl: cycle-exact directed sequences plus a
// scoreboard of expected SRAM reads and writes popped as granted accesses appear.
module tb_llc_set_buf_ctrl;

  localparam int unsigned WAYS     = 16;
  localparam int unsigned WAY_BITS = 4;
  localparam int unsigned SET_BITS = 9;

  logic                clk = 1'b0;
  logic                rst;
  logic                rst_state;
  logic                req_valid;
  logic                req_ready;
  logic [SET_BITS-1:0] req_set;
  logic                mem_gnt;
  logic                mem_rd_en;
  logic                mem_wr_en;
  logic [SET_BITS-1:0] mem_set;
  logic [WAY_BITS-1:0] mem_way;
  logic                buf_load;
  logic                busy;
  logic                release_vld;
  logic                release_wb;
  logic [WAYS-1:0]     dirty_bits;
  logic                done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [SET_BITS-1:0]          rd_q[$];
  logic [SET_BITS+WAY_BITS-1:0] wr_q[$];
  logic [SET_BITS-1:0]          cur_set;

  llc_set_buf_ctrl #(.WAYS(WAYS), .WAY_BITS(WAY_BITS), .SET_BITS(SET_BITS)) dut (
    .clk(clk), .rst(rst), .rst_state(rst_state),
    .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set),
    .mem_gnt(mem_gnt), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_set(mem_set), .mem_way(mem_way), .buf_load(buf_load), .busy(busy),
    .release_vld(release_vld), .release_wb(release_wb),
    .dirty_bits(dirty_bits), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Granted SRAM accesses are matched against the scoreboard at the falling edge.
  always @(negedge clk) begin
    logic [SET_BITS-1:0]          er;
    logic [SET_BITS+WAY_BITS-1:0] ew;
    if (rst) begin
      if (mem_rd_en && mem_wr_en) check_eq("rd_wr_exclusive", 1, 0);
      if (mem_rd_en && mem_gnt) begin
        if (rd_q.size() == 0) check_eq("rd_unexpected", 32'(mem_set), 32'h1ff0000);
        else begin
          er = rd_q.pop_front();
          check_eq("rd_set", 32'(mem_set), 32'(er));
        end
      end
      if (mem_wr_en && mem_gnt) begin
        if (wr_q.size() == 0) check_eq("wr_unexpected", 32'({mem_set, mem_way}), 32'h1ff0000);
        else begin
          ew = wr_q.pop_front();
          check_eq("wr_set_way", 32'({mem_set, mem_way}), 32'(ew));
        end
      end
    end
  end

  task automatic do_fetch(input logic [SET_BITS-1:0] set, input int stall);
    req_valid = 1'b1;
    req_set   = set;
    mem_gnt   = 1'b1;
    cur_set   = set;
    rd_q.push_back(set);
    #1;
    check_eq("fetch_idle_ready", 32'(req_ready), 1);
    check_eq("fetch_idle_rd", 32'(mem_rd_en), 0);
    cyc();
    req_valid = 1'b0;
    repeat (stall) begin
      mem_gnt = 1'b0;
      #1;
      check_eq("rd_stall_hold", 32'(mem_rd_en), 1);
      check_eq("rd_stall_load", 32'(buf_load), 0);
      check_eq("rd_stall_ready", 32'(req_ready), 0);
      cyc();
    end
    mem_gnt = 1'b1;
    #1;
    check_eq("rd_en", 32'(mem_rd_en), 1);
    check_eq("rd_mem_set", 32'(mem_set), 32'(set));
    cyc();
    #1;
    check_eq("buf_load", 32'(buf_load), 1);
    check_eq("latch_rd_off", 32'(mem_rd_en), 0);
    cyc();
    #1;
    check_eq("own_busy", 32'(busy), 1);
    check_eq("own_load_off", 32'(buf_load), 0);
  endtask

  task automatic do_wb(input logic [WAYS-1:0] dirty, input int stall_way, input int stall_n,
                       input bit clean_gnt, input bit toggle, input int abort_at);
    dirty_bits  = dirty;
    release_vld = 1'b1;
    release_wb  = 1'b1;
    mem_gnt     = 1'b1;
    for (int w = 0; w < int'(WAYS); w++)
      if (dirty[w] && (abort_at < 0 || w < abort_at))
        wr_q.push_back({cur_set, WAY_BITS'(w)});
    #1;
    check_eq("wb_release_done", 32'(done), 0);
    cyc();
    release_vld = 1'b0;
    release_wb  = 1'b0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (toggle) dirty_bits = ~dirty_bits;
      if (w == abort_at) begin
        rst_state = 1'b1;
        mem_gnt   = 1'b0;
        #1;
        check_eq("abort_way", 32'(mem_way), 32'(w));
        check_eq("abort_no_done", 32'(done), 0);
        cyc();
        rst_state = 1'b0;
        mem_gnt   = 1'b1;
        #1;
        check_eq("abort_idle", 32'(req_ready), 1);
        check_eq("abort_no_wr", 32'(mem_wr_en), 0);
        cyc();
        #1;
        check_eq("abort_still_idle", 32'(req_ready), 1);
        check_eq("abort_no_done2", 32'(done), 0);
        return;
      end
      if (w == stall_way) begin
        repeat (stall_n) begin
          mem_gnt = 1'b0;
          #1;
          check_eq("wb_stall_way", 32'(mem_way), 32'(w));
          check_eq("wb_stall_wr", 32'(mem_wr_en), 32'(dirty[w]));
          check_eq("wb_stall_done", 32'(done), 0);
          cyc();
        end
      end
      mem_gnt = dirty[w] ? 1'b1 : clean_gnt;
      #1;
      check_eq("wb_way", 32'(mem_way), 32'(w));
      check_eq("wb_wr_en", 32'(mem_wr_en), 32'(dirty[w]));
      check_eq("wb_done", 32'(done), 32'(w == int'(WAYS) - 1));
      cyc();
    end
    mem_gnt    = 1'b1;
    dirty_bits = '0;
    #1;
    check_eq("wb_end_ready", 32'(req_ready), 1);
    check_eq("wb_end_done", 32'(done), 0);
    check_eq("wb_end_wr", 32'(mem_wr_en), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; rst_state = 1'b0; req_valid = 1'b0; req_set = '0; mem_gnt = 1'b1;
    release_vld = 1'b0; release_wb = 1'b0; dirty_bits = '0; cur_set = '0;
    #3;
    check_eq("rst_ready", 32'(req_ready), 1);
    check_eq("rst_outs", 32'({mem_rd_en, mem_wr_en, buf_load, busy, done}), 0);
    check_eq("rst_set_way", 32'({mem_set, mem_way}), 0);
    cyc();
    rst = 1'b1;
    cyc();

    // Single request without write-back.
    do_fetch(9'h05A, 0);
    release_vld = 1'b1;
    #1;
    check_eq("rel_done", 32'(done), 1);
    cyc();
    release_vld = 1'b0;
    #1;
    check_eq("rel_ready", 32'(req_ready), 1);
    check_eq("rel_done_pulse", 32'(done), 0);

    do_fetch(9'h1F3, 3);
    do_wb(16'h8001, -1, 0, 1'b1, 1'b0, -1);

    do_fetch(9'h0A0, 0);
    do_wb(16'h0111, 4, 2, 1'b0, 1'b0, -1);

    do_fetch(9'h123, 0);
    do_wb(16'hF00F, -1, 0, 1'b1, 1'b0, 7);

    // Request held while buffers are owned must wait for IDLE.
    do_fetch(9'h0C4, 0);
    req_valid = 1'b1;
    req_set   = 9'h1C3;
    repeat (2) begin
      #1;
      check_eq("own_hold_ready", 32'(req_ready), 0);
      check_eq("own_hold_rd", 32'(mem_rd_en), 0);
      check_eq("own_hold_busy", 32'(busy), 1);
      cyc();
    end
    release_vld = 1'b1;
    #1;
    check_eq("own_hold_done", 32'(done), 1);
    cyc();
    release_vld = 1'b0;
    do_fetch(9'h1C3, 0);
    do_wb(16'h5A5A, -1, 0, 1'b1, 1'b1, -1);

    // Asynchronous reset in the middle of a stalled write-back.
    do_fetch(9'h077, 0);
    dirty_bits = 16'hFFFF; release_vld = 1'b1; release_wb = 1'b1;
    cyc();
    release_vld = 1'b0; release_wb = 1'b0; mem_gnt = 1'b0;
    #1;
    check_eq("pre_rst_wr", 32'(mem_wr_en), 1);
    cyc();
    rst = 1'b0;
    #1;
    check_eq("mid_rst_ready", 32'(req_ready), 1);
    check_eq("mid_rst_outs", 32'({mem_rd_en, mem_wr_en, buf_load, busy, done}), 0);
    check_eq("mid_rst_set_way", 32'({mem_set, mem_way}), 0);
    cyc();
    rst = 1'b1; mem_gnt = 1'b1; dirty_bits = '0;
    cyc();
    do_fetch(9'h0E1, 1);
    do_wb(16'h0402, -1, 0, 1'b0, 1'b0, -1);

    cyc();
    check_eq("rd_q_drained", 32'(rd_q.size()), 0);
    check_eq("wr_q_drained", 32'(wr_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
